// File: rtl/donut_pkg.sv
// ============================================================================
// Module : donut_pkg
// Shared constants, Bayer table and pixel typedef for the donut shading stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package donut_pkg;

  localparam int LUMA_W  = 6;
  localparam int LEVEL_W = 2;

  // 4x4 ordered-dither thresholds, entry {row,col} at bits [4*idx +: 4]
  localparam logic [63:0] BAYER4 = {
    4'd5, 4'd13, 4'd7,  4'd15,
    4'd9, 4'd1,  4'd11, 4'd3,
    4'd6, 4'd14, 4'd4,  4'd12,
    4'd10, 4'd2, 4'd8,  4'd0
  };

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  function automatic logic [3:0] bayer_lookup(input logic [3:0] idx);
    return BAYER4[{idx, 2'b00} +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/donut_dither.sv
// ============================================================================
// Module : donut_dither
// Adds a Bayer threshold to a 6-bit value and saturates to a 2-bit level.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module donut_dither
  import donut_pkg::*;
(
  input  logic [LUMA_W-1:0]  value,
  input  logic [3:0]         t,
  output logic [LEVEL_W-1:0] level
);

  logic [LUMA_W:0] w_sum;

  assign w_sum = {1'b0, value} + {3'b000, t};
  // Carry into bit 6 means the sum passed 63: clamp instead of wrapping
  assign level = w_sum[LUMA_W] ? 2'd3 : w_sum[5:4];

endmodule

`default_nettype wire

// File: rtl/donut_shade.sv
// ============================================================================
// Module : donut_shade
// Two-stage pixel shader: Bayer-dithered tinted donut over a scrolling blue
// gradient, with syncs delayed to match. Define DONUT_SHADE_TEMPORAL_EN to
// rotate the dither pattern every frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module donut_shade
  import donut_pkg::*;
#(
  parameter int         HSHIFT    = 1,
  parameter logic [2:0] TINT      = 3'b110,
  parameter logic       SYNC_IDLE = 1'b1,
  parameter logic       BG_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       h_count,
  input  logic [9:0]        v_count,
  input  logic              display_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              donut_visible,
  input  logic [LUMA_W-1:0] donut_luma,
  output logic [5:0]        rgb,
  output logic              hsync,
  output logic              vsync
);

  logic [1:0]        w_h_idx;
  logic [3:0]        w_bayer_idx;
  logic [5:0]        w_bg;
  logic              w_tick;
  logic              w_unused;

  logic              r_s1_disp;
  logic              r_s1_hs;
  logic              r_s1_vs;
  logic              r_s1_vis;
  logic [LUMA_W-1:0] r_s1_luma;
  logic [3:0]        r_s1_t;
  logic [5:0]        r_s1_bg;
  logic              r_vs_prev;
  logic [1:0]        r_frame;
  logic [5:0]        r_scroll;

  assign w_h_idx = h_count[HSHIFT+1:HSHIFT];

`ifdef DONUT_SHADE_TEMPORAL_EN
  assign w_bayer_idx = {v_count[1:0] ^ r_frame, w_h_idx ^ {r_frame[0], r_frame[1]}};
`else
  assign w_bayer_idx = {v_count[1:0], w_h_idx};
`endif

  assign w_bg     = {1'b0, v_count[8:4]} + r_scroll;
  assign w_tick   = r_vs_prev & ~r_s1_vs;
  assign w_unused = ^{h_count, v_count[9], r_frame};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_disp <= 1'b0;
      r_s1_hs   <= SYNC_IDLE;
      r_s1_vs   <= SYNC_IDLE;
      r_s1_vis  <= 1'b0;
      r_s1_luma <= '0;
      r_s1_t    <= '0;
      r_s1_bg   <= '0;
    end else begin
      r_s1_disp <= display_on;
      r_s1_hs   <= hsync_in;
      r_s1_vs   <= vsync_in;
      r_s1_vis  <= donut_visible;
      r_s1_luma <= donut_luma;
      r_s1_t    <= bayer_lookup(w_bayer_idx);
      r_s1_bg   <= w_bg;
    end
  end

  // Edge detector starts at 0 so release from reset never fakes a frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev <= 1'b0;
      r_frame   <= '0;
      r_scroll  <= '0;
    end else begin
      r_vs_prev <= r_s1_vs;
      if (w_tick) begin
        r_frame  <= r_frame + 2'd1;
        r_scroll <= r_scroll + 6'd1;
      end
    end
  end

  logic [LUMA_W-1:0]  w_value;
  logic [LEVEL_W-1:0] w_level;
  logic [LEVEL_W-1:0] w_half;
  rgb222_t            w_rgb;

  assign w_value = r_s1_vis ? r_s1_luma : r_s1_bg;

  donut_dither u_dither (
    .value (w_value),
    .t     (r_s1_t),
    .level (w_level)
  );

  assign w_half = {1'b0, w_level[1]};

  always_comb begin
    w_rgb = '0;
    if (r_s1_disp) begin
      if (r_s1_vis) begin
        w_rgb.r = TINT[2] ? w_level : w_half;
        w_rgb.g = TINT[1] ? w_level : w_half;
        w_rgb.b = TINT[0] ? w_level : w_half;
      end else if (BG_EN) begin
        w_rgb.b = w_level;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb   <= '0;
      hsync <= SYNC_IDLE;
      vsync <= SYNC_IDLE;
    end else begin
      rgb   <= w_rgb;
      hsync <= r_s1_hs;
      vsync <= r_s1_vs;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_donut_shade.sv
// ============================================================================
// Module : tb_donut_shade
// Directed self-checking bench for donut_shade (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_donut_shade;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        display_on;
  logic        hsync_in;
  logic        vsync_in;
  logic        donut_visible;
  logic [5:0]  donut_luma;
  logic [5:0]  rgb;
  logic        hsync;
  logic        vsync;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] tb_bayer [16] = '{4'd0, 4'd8, 4'd2, 4'd10, 4'd12, 4'd4, 4'd14, 4'd6,
                                4'd3, 4'd11, 4'd1, 4'd9, 4'd15, 4'd7, 4'd13, 4'd5};

  always #5 clk = ~clk;

  donut_shade dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .h_count       (h_count),
    .v_count       (v_count),
    .display_on    (display_on),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .donut_visible (donut_visible),
    .donut_luma    (donut_luma),
    .rgb           (rgb),
    .hsync         (hsync),
    .vsync         (vsync)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic disp, input logic hs, input logic vs, input logic vis,
                       input logic [5:0] luma, input logic [10:0] h, input logic [9:0] v);
    display_on    = disp;
    hsync_in      = hs;
    vsync_in      = vs;
    donut_visible = vis;
    donut_luma    = luma;
    h_count       = h;
    v_count       = v;
  endtask

  // TINT=110: r,g full level, b halved
  function automatic logic [5:0] donut_rgb(input logic [1:0] lvl);
    return {lvl, lvl, 1'b0, lvl[1]};
  endfunction

  function automatic logic [1:0] sat_level(input int sum);
    return (sum >= 48) ? 2'd3 : 2'(sum / 16);
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd63, 11'd0, 10'd0);
    step(); step(); step();
    n_checks++;
    if (rgb !== 6'b111101) begin
      n_fail++; $display("FAIL reset_pre_rgb: got %b want %b", rgb, 6'b111101);
    end
    n_checks++;
    if (hsync !== 1'b0 || vsync !== 1'b0) begin
      n_fail++; $display("FAIL reset_pre_sync: got %b%b want 00", hsync, vsync);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rgb !== 6'd0) begin
      n_fail++; $display("FAIL reset_async_rgb: got %b want 000000", rgb);
    end
    n_checks++;
    if (hsync !== 1'b1 || vsync !== 1'b1) begin
      n_fail++; $display("FAIL reset_async_sync: got %b%b want 11", hsync, vsync);
    end
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (rgb !== 6'd0 || hsync !== 1'b1) begin
      n_fail++; $display("FAIL reset_one_clk: got rgb %b hs %b want 000000 1", rgb, hsync);
    end
    step();
    n_checks++;
    if (rgb !== 6'b111101 || hsync !== 1'b0 || vsync !== 1'b0) begin
      n_fail++; $display("FAIL reset_two_clk: got rgb %b hs %b vs %b want 111101 0 0",
                         rgb, hsync, vsync);
    end
  endtask

  task automatic test_saturate();
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 4; h++) begin
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd63, 11'(h * 2), 10'(v));
        step(); step();
        n_checks++;
        if (rgb !== 6'b111101) begin
          n_fail++; $display("FAIL saturate v%0d h%0d: got %b want 111101", v, h, rgb);
        end
      end
    end
  endtask

  task automatic test_luma40();
    int         cnt3;
    logic [5:0] exp;
    cnt3 = 0;
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 4; h++) begin
        exp = donut_rgb(sat_level(40 + int'(tb_bayer[v * 4 + h])));
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd40, 11'(h * 2 + 64), 10'(v + 8));
        step(); step();
        n_checks++;
        if (rgb !== exp) begin
          n_fail++; $display("FAIL luma40 v%0d h%0d: got %b want %b", v, h, rgb, exp);
        end
        if (rgb === 6'b111101) cnt3++;
      end
    end
    n_checks++;
    if (cnt3 != 8) begin
      n_fail++; $display("FAIL luma40_count3: got %0d want 8", cnt3);
    end
  endtask

  task automatic test_sync_stream();
    logic hs_p, vs_p, disp_p, hs_c, vs_c, disp_c;
    hs_p = 1'b0; vs_p = 1'b0; disp_p = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hs_c   = 1'($urandom_range(0, 1));
      vs_c   = 1'($urandom_range(0, 1));
      disp_c = 1'($urandom_range(0, 1));
      drive(disp_c, hs_c, vs_c, 1'b1, 6'd63, 11'd0, 10'd0);
      step();
      if (i > 0) begin
        n_checks++;
        if (hsync !== hs_p || vsync !== vs_p) begin
          n_fail++; $display("FAIL sync_delay i%0d: got %b%b want %b%b", i, hsync, vsync, hs_p, vs_p);
        end
        n_checks++;
        if (rgb !== (disp_p ? 6'b111101 : 6'd0)) begin
          n_fail++; $display("FAIL blank_delay i%0d: got %b disp %b", i, rgb, disp_p);
        end
      end
      hs_p = hs_c; vs_p = vs_c; disp_p = disp_c;
    end
  endtask

  task automatic test_scroll();
    logic [1:0] lvl;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 11'd0, 10'd0);
    pulse_reset();
    step(); step(); step();
    n_checks++;
    if (rgb !== 6'd0) begin
      n_fail++; $display("FAIL scroll_e0: got %b want 000000", rgb);
    end
    for (int e = 1; e <= 64; e++) begin
      vsync_in = 1'b1; step();
      vsync_in = 1'b0; step();
      if (e % 16 == 0) begin
        step(); step(); step();
        lvl = 2'((e / 16) % 4);
        n_checks++;
        if (rgb !== {4'b0000, lvl}) begin
          n_fail++; $display("FAIL scroll_e%0d: got %b want %b", e, rgb, {4'b0000, lvl});
        end
      end
    end
  endtask

  task automatic test_temporal();
    logic [1:0] f;
    logic [1:0] lvl;
    logic [3:0] idx;
    int         n1;
    n1 = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd8, 11'd0, 10'd0);
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      f = 2'(k);
      if (k > 0) begin
        vsync_in = 1'b1; step();
        vsync_in = 1'b0; step();
      end
      step(); step(); step();
`ifdef DONUT_SHADE_TEMPORAL_EN
      idx = {2'b00 ^ f, 2'b00 ^ {f[0], f[1]}};
`else
      idx = 4'd0;
`endif
      lvl = sat_level(8 + int'(tb_bayer[idx]));
      n_checks++;
      if (rgb !== donut_rgb(lvl)) begin
        n_fail++; $display("FAIL temporal_f%0d: got %b want %b", k, rgb, donut_rgb(lvl));
      end
      if (rgb === 6'b010100) n1++;
    end
    n_checks++;
`ifdef DONUT_SHADE_TEMPORAL_EN
    if (n1 != 2) begin
      n_fail++; $display("FAIL temporal_level1_count: got %0d want 2", n1);
    end
`else
    if (n1 != 0) begin
      n_fail++; $display("FAIL temporal_level1_count: got %0d want 0", n1);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 11'd0, 10'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_saturate();
    test_luma40();
    test_sync_stream();
    test_scroll();
    test_temporal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
